// File: rtl/softmc_pcie_bridge.sv
// rtl/softmc_pcie_bridge.sv - RIFFA channel bridge between PCIe host and SoftMC instruction/readback paths
//
// Purpose: unpacks RX channel words into 32-bit SoftMC instructions and streams
// readback FIFO entries back to the host as one TX transaction per entry.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   CHNL_RX_*            : RIFFA RX channel (host -> bridge), instruction words
//   CHNL_TX_*            : RIFFA TX channel (bridge -> host), readback entries
//   app_en/app_ack       : instruction valid / taken handshake toward SoftMC
//   app_instr            : current 32-bit instruction
//   rdback_fifo_*        : first-word-fall-through readback FIFO read side
//   rdback_data          : FIFO head entry, DQ_WIDTH*4 bits
module softmc_pcie_bridge #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int DQ_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          CHNL_RX_CLK,
  input  logic                          CHNL_RX,
  output logic                          CHNL_RX_ACK,
  input  logic                          CHNL_RX_LAST,
  input  logic [31:0]                   CHNL_RX_LEN,
  input  logic [30:0]                   CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0]   CHNL_RX_DATA,
  input  logic                          CHNL_RX_DATA_VALID,
  output logic                          CHNL_RX_DATA_REN,
  output logic                          CHNL_TX_CLK,
  output logic                          CHNL_TX,
  input  logic                          CHNL_TX_ACK,
  output logic                          CHNL_TX_LAST,
  output logic [31:0]                   CHNL_TX_LEN,
  output logic [30:0]                   CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]   CHNL_TX_DATA,
  output logic                          CHNL_TX_DATA_VALID,
  input  logic                          CHNL_TX_DATA_REN,
  output logic                          app_en,
  input  logic                          app_ack,
  output logic [31:0]                   app_instr,
  input  logic                          rdback_fifo_empty,
  output logic                          rdback_fifo_rden,
  input  logic [DQ_WIDTH*4-1:0]         rdback_data
);

  localparam int ENTRY_W = DQ_WIDTH * 4;
  localparam int IPW     = C_PCI_DATA_WIDTH / 32;
  localparam int BEATS   = ENTRY_W / C_PCI_DATA_WIDTH;
  localparam int SLOT_W  = (IPW > 1) ? $clog2(IPW) : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(IPW - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Transaction length/offset from the host are not needed: every RX word is
  // simply a bundle of instructions.
  logic unused_rx_info;
  assign unused_rx_info = ^{CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF};

  assign CHNL_RX_CLK  = clk;
  assign CHNL_TX_CLK  = clk;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_LEN  = 32'(ENTRY_W / 32);

  // RX transaction ack: edge detect, then a one-cycle pulse a cycle later.
  logic rx_prev;
  logic rx_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev     <= 1'b0;
      rx_pending  <= 1'b0;
      CHNL_RX_ACK <= 1'b0;
    end else begin
      rx_prev     <= CHNL_RX;
      rx_pending  <= CHNL_RX & ~rx_prev;
      CHNL_RX_ACK <= rx_pending;
    end
  end

  // RX unpack: one word held, instructions issued slot by slot.
  logic [C_PCI_DATA_WIDTH-1:0] rx_hold;
  logic                        rx_full;
  logic [SLOT_W-1:0]           rx_slot;
  logic                        instr_take;
  logic                        rx_load;

  assign instr_take = rx_full & app_ack;
  // Accepting the last slot frees the register in the same cycle, so the next
  // word can be loaded without a bubble. Gated by rst_n so REN is low in reset.
  assign CHNL_RX_DATA_REN = rst_n & (~rx_full | (instr_take & (rx_slot == LAST_SLOT)));
  assign rx_load   = CHNL_RX_DATA_VALID & CHNL_RX_DATA_REN;
  assign app_en    = rx_full;
  assign app_instr = rx_hold[int'(rx_slot)*32 +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
      rx_slot <= '0;
    end else if (rx_load) begin
      rx_hold <= CHNL_RX_DATA;
      rx_full <= 1'b1;
      rx_slot <= '0;
    end else if (instr_take) begin
      if (rx_slot == LAST_SLOT) begin
        rx_full <= 1'b0;
        rx_slot <= '0;
      end else begin
        rx_slot <= rx_slot + 1'b1;
      end
    end
  end

  // TX path: one readback entry per TX transaction.
  typedef enum logic [1:0] {TX_IDLE, TX_OPEN, TX_SEND, TX_DONE} tx_state_t;

  tx_state_t          state, state_n;
  logic [BEAT_W-1:0]  beat, beat_n;
  logic [ENTRY_W-1:0] entry;
  logic               capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
      beat  <= '0;
      entry <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (capture) entry <= rdback_data;
    end
  end

  always_comb begin
    state_n            = state;
    beat_n             = beat;
    capture            = 1'b0;
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    CHNL_TX_DATA       = '0;
    rdback_fifo_rden   = 1'b0;
    case (state)
      TX_IDLE: begin
        rdback_fifo_rden = rst_n & ~rdback_fifo_empty;
        if (!rdback_fifo_empty) begin
          capture = 1'b1;
          beat_n  = '0;
          state_n = TX_OPEN;
        end
      end
      TX_OPEN, TX_SEND: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_DATA_VALID = 1'b1;
        CHNL_TX_DATA       = entry[int'(beat)*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
        if (state == TX_OPEN && CHNL_TX_ACK) state_n = TX_SEND;
        // The host may start reading before its ack is seen; those beats count.
        if (CHNL_TX_DATA_REN) begin
          if (beat == LAST_BEAT) begin
            beat_n  = '0;
            state_n = TX_DONE;
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      TX_DONE: state_n = TX_IDLE;
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_softmc_pcie_bridge.sv
// tb/tb_softmc_pcie_bridge.sv - self-checking bench for softmc_pcie_bridge (W=64, DQ=64)
module tb_softmc_pcie_bridge;

  localparam int W     = 64;
  localparam int DQ    = 64;
  localparam int EW    = DQ * 4;
  localparam int BEATS = EW / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          CHNL_RX_CLK, CHNL_RX, CHNL_RX_ACK, CHNL_RX_LAST;
  logic [31:0]   CHNL_RX_LEN;
  logic [30:0]   CHNL_RX_OFF;
  logic [W-1:0]  CHNL_RX_DATA;
  logic          CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN;
  logic          CHNL_TX_CLK, CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST;
  logic [31:0]   CHNL_TX_LEN;
  logic [30:0]   CHNL_TX_OFF;
  logic [W-1:0]  CHNL_TX_DATA;
  logic          CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;
  logic          app_en, app_ack;
  logic [31:0]   app_instr;
  logic          rdback_fifo_empty, rdback_fifo_rden;
  logic [EW-1:0] rdback_data;

  softmc_pcie_bridge #(.C_PCI_DATA_WIDTH(W), .DQ_WIDTH(DQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK),
    .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF),
    .CHNL_RX_DATA(CHNL_RX_DATA), .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
    .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
    .CHNL_TX_CLK(CHNL_TX_CLK), .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK),
    .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
    .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN),
    .app_en(app_en), .app_ack(app_ack), .app_instr(app_instr),
    .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden),
    .rdback_data(rdback_data)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0]   exp_instr[$];
  logic          h1, h2, h3;
  logic [EW-1:0] fifo_q[$];
  logic          tx_busy, tx_gap;
  logic [EW-1:0] tx_entry;
  int            tx_beat;
  logic          ev_acc, ev_hs, ev_beat, ev_pop;
  int            rden_cnt, done_cnt;
  bit            rnd;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] rand_entry();
    logic [EW-1:0] e;
    for (int i = 0; i < EW / 32; i++) e[i*32 +: 32] = $urandom();
    return e;
  endfunction

  task automatic model_reset();
    exp_instr.delete();
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    tx_busy = 1'b0; tx_gap = 1'b0; tx_beat = 0;
    ev_acc = 1'b0; ev_hs = 1'b0; ev_beat = 1'b0; ev_pop = 1'b0;
  endtask

  // Compare DUT outputs with the model for the current cycle and note the
  // events the coming clock edge will perform.
  task automatic model_check();
    int   n;
    logic exp_en, exp_ren, exp_rden;
    n      = exp_instr.size();
    exp_en = (n > 0);
    chk("rx_ack", CHNL_RX_ACK, h2 & ~h3);
    chk("app_en", app_en, exp_en);
    if (exp_en) chk("app_instr", app_instr, exp_instr[0]);
    ev_hs   = exp_en && app_ack;
    exp_ren = (n == 0) || (n == 1 && ev_hs);
    chk("rx_ren", CHNL_RX_DATA_REN, exp_ren);
    ev_acc  = CHNL_RX_DATA_VALID && exp_ren;
    chk("tx", CHNL_TX, tx_busy);
    chk("tx_valid", CHNL_TX_DATA_VALID, tx_busy);
    if (tx_busy) chk("tx_data", CHNL_TX_DATA, tx_entry[tx_beat*W +: W]);
    exp_rden = !tx_busy && !tx_gap && (fifo_q.size() > 0);
    chk("rden", rdback_fifo_rden, exp_rden);
    ev_pop  = exp_rden;
    ev_beat = tx_busy && CHNL_TX_DATA_REN;
    chk("tx_len", CHNL_TX_LEN, 8);
    chk("tx_off", CHNL_TX_OFF, 0);
    chk("tx_last", CHNL_TX_LAST, 1);
    if (rdback_fifo_rden) rden_cnt++;
  endtask

  task automatic model_apply();
    if (ev_hs) void'(exp_instr.pop_front());
    if (ev_acc) begin
      exp_instr.push_back(CHNL_RX_DATA[31:0]);
      exp_instr.push_back(CHNL_RX_DATA[63:32]);
    end
    h3 = h2; h2 = h1; h1 = CHNL_RX;
    if (tx_busy) begin
      if (ev_beat) begin
        tx_beat++;
        if (tx_beat == BEATS) begin
          tx_busy = 1'b0;
          tx_gap  = 1'b1;
          done_cnt++;
        end
      end
    end else if (tx_gap) begin
      tx_gap = 1'b0;
    end else if (ev_pop) begin
      tx_entry = fifo_q.pop_front();
      tx_busy  = 1'b1;
      tx_beat  = 0;
    end
  endtask

  task automatic drive_fifo();
    rdback_fifo_empty = (fifo_q.size() == 0);
    rdback_data       = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic drive_random();
    if (!(CHNL_RX_DATA_VALID && !ev_acc)) begin
      CHNL_RX_DATA_VALID = ($urandom_range(0, 2) != 0);
      CHNL_RX_DATA       = {$urandom(), $urandom()};
    end
    app_ack = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) CHNL_RX = ~CHNL_RX;
    CHNL_TX_DATA_REN = ($urandom_range(0, 3) != 0);
    CHNL_TX_ACK      = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) fifo_q.push_back(rand_entry());
  endtask

  // Check at the falling edge, advance the model just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    model_apply();
    if (rnd) drive_random();
    drive_fifo();
  endtask

  task automatic check_reset_outputs();
    chk("rst_rx_ack", CHNL_RX_ACK, 0);
    chk("rst_rx_ren", CHNL_RX_DATA_REN, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_tx", CHNL_TX, 0);
    chk("rst_tx_valid", CHNL_TX_DATA_VALID, 0);
    chk("rst_rden", rdback_fifo_rden, 0);
  endtask

  initial begin
    logic [EW-1:0] ka, kb, next_entry;
    bit found;
    rst_n = 1'b0;
    CHNL_RX = 1'b0; CHNL_RX_LAST = 1'b0; CHNL_RX_LEN = '0; CHNL_RX_OFF = '0;
    CHNL_RX_DATA = '0; CHNL_RX_DATA_VALID = 1'b0;
    CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b0; app_ack = 1'b0;
    rnd = 1'b0; rden_cnt = 0; done_cnt = 0;
    model_reset();
    drive_fifo();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    chk("rst_tx_len", CHNL_TX_LEN, 8);
    chk("rx_clk", CHNL_RX_CLK, clk);
    chk("tx_clk", CHNL_TX_CLK, clk);
    rst_n = 1'b1;

    // RX ack pulse two cycles after CHNL_RX rises, single cycle only
    CHNL_RX = 1'b1;
    tick(); chk("ack_c1", CHNL_RX_ACK, 0);
    tick(); chk("ack_c2", CHNL_RX_ACK, 1);
    tick(); chk("ack_c3", CHNL_RX_ACK, 0);
    tick(); chk("ack_c4", CHNL_RX_ACK, 0);

    // Instruction held without app_ack, REN low until consumed
    CHNL_RX_DATA_VALID = 1'b1; CHNL_RX_DATA = 64'hCAFEF00D_DEADBEEF; app_ack = 1'b0;
    tick(); CHNL_RX_DATA_VALID = 1'b0;
    chk("hold_en", app_en, 1);
    chk("hold_instr", app_instr, 32'hDEADBEEF);
    tick(); tick();
    chk("hold_ren_low", CHNL_RX_DATA_REN, 0);
    chk("hold_stable", app_instr, 32'hDEADBEEF);
    app_ack = 1'b1;
    tick(); chk("hold_slot1", app_instr, 32'hCAFEF00D);
    tick(); chk("hold_empty", app_en, 0);

    // Back-to-back slots with app_ack held
    CHNL_RX_DATA_VALID = 1'b1; CHNL_RX_DATA = 64'h11111111_22222222;
    tick(); CHNL_RX_DATA_VALID = 1'b0;
    chk("b2b_slot0", app_instr, 32'h22222222);
    tick(); chk("b2b_slot1", app_instr, 32'h11111111);
    chk("b2b_en", app_en, 1);
    tick(); chk("b2b_empty", app_en, 0);

    // One entry, REN always high: lanes 1,2,3,4 then a low cycle
    CHNL_TX_DATA_REN = 1'b1; CHNL_TX_ACK = 1'b1;
    fifo_q.push_back({64'h4, 64'h3, 64'h2, 64'h1});
    drive_fifo();
    tick(); chk("tx_open", CHNL_TX, 1); chk("tx_beat1", CHNL_TX_DATA, 64'h1);
    tick(); chk("tx_beat2", CHNL_TX_DATA, 64'h2);
    tick(); chk("tx_beat3", CHNL_TX_DATA, 64'h3);
    tick(); chk("tx_beat4", CHNL_TX_DATA, 64'h4);
    tick(); chk("tx_done_low", CHNL_TX, 0);
    tick(); chk("tx_idle_low", CHNL_TX, 0);

    // Two entries, REN toggling
    rden_cnt = 0; done_cnt = 0;
    fifo_q.push_back(rand_entry());
    fifo_q.push_back(rand_entry());
    drive_fifo();
    for (int i = 0; i < 100 && done_cnt < 2; i++) begin
      CHNL_TX_DATA_REN = (i % 2 == 0);
      tick();
    end
    chk("two_done", done_cnt, 2);
    chk("two_rden_pulses", rden_cnt, 2);

    // Randomized traffic on both paths
    rnd = 1'b1;
    repeat (3000) tick();

    // Reset in the middle of beat 2
    ka = rand_entry(); kb = rand_entry();
    fifo_q.push_back(ka); fifo_q.push_back(kb);
    drive_fifo();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_busy && tx_beat == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("beat2_reached", found, 1);
    chk("beat2_data", CHNL_TX_DATA, tx_entry[2*W +: W]);
    if (fifo_q.size() == 0) fifo_q.push_back(ka);
    next_entry = fifo_q[0];
    drive_fifo();
    rst_n = 1'b0; CHNL_RX = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("post_rst_started", found, 1);
    chk("post_rst_beat0", CHNL_TX_DATA, next_entry[W-1:0]);

    repeat (500) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
